imm_extender_pipe: RTL and testbench

Pipelined, parametrised immediate generator between decode and execute. It accepts an instruction word plus an immediate-format selector over a valid/ready handshake. It produces the sign- or zero-extended immediate at XLEN bits, with a registered output and a 2-entry skid buffer, so decode stalls never create a combinational ready path. An optional tag (PC or ROB index) travels alongside each immediate, and flush discards all in-flight entries.

---
 rtl/riscv_defines.sv | 46 ++++
 rtl/imm_extend_core.sv | 53 +++++
 rtl/imm_extender_pipe.sv | 127 ++++++++++++
 tb/tb_imm_extender_pipe.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_defines.sv
// Shared types for the immediate extender slice.
//   inst_t       : 32-bit instruction word
//   immsrc_t     : immediate format selector (compressed formats only when
//                  IMM_EXTENDER_RVC_EN is defined)
//   state_e      : occupancy state of the output/skid register pair
//   XLEN_DEFAULT : default datapath width
package riscv_defines;

  localparam int XLEN_DEFAULT = 32;

  typedef logic [31:0] inst_t;

  // Four bits so the compressed formats fit; values with no member are
  // unsupported and come out flagged as errors.
`ifdef IMM_EXTENDER_RVC_EN
  typedef enum logic [3:0] {
    IMM_I  = 4'd0,
    IMM_S  = 4'd1,
    IMM_B  = 4'd2,
    IMM_U  = 4'd3,
    IMM_J  = 4'd4,
    IMM_Z  = 4'd5,
    IMM_CI = 4'd6,
    IMM_CB = 4'd7,
    IMM_CJ = 4'd8
  } immsrc_t;
`else
  typedef enum logic [3:0] {
    IMM_I  = 4'd0,
    IMM_S  = 4'd1,
    IMM_B  = 4'd2,
    IMM_U  = 4'd3,
    IMM_J  = 4'd4,
    IMM_Z  = 4'd5
  } immsrc_t;
`endif

  // bit0 = output register valid, bit1 = skid register valid, so each
  // valid bit (and in_ready) is read straight off a state flop.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } state_e;

endpackage

// File: rtl/imm_extend_core.sv
// Combinational immediate decode.
//   inst   : instruction word
//   immsrc : format selector
//   imm    : immediate extended to XLEN (0 for unsupported formats)
//   err    : immsrc has no decode in this build
// Macro IMM_EXTENDER_RVC_EN adds the compressed CI/CB/CJ formats.
module imm_extend_core
  import riscv_defines::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  inst_t            inst,
  input  immsrc_t          immsrc,
  output logic [XLEN-1:0]  imm,
  output logic             err
);

  // Every format fits in 32 bits; build that first, then widen by
  // replicating bit 31 (IMM_Z has bit 31 clear, so it stays zero-extended).
  logic [31:0] imm32;
  logic        unused_low;

  assign unused_low = ^inst[6:0];

  always_comb begin
    imm32 = '0;
    err   = 1'b0;
    case (immsrc)
      IMM_I:  imm32 = {{20{inst[31]}}, inst[31:20]};
      IMM_S:  imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:  imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25],
                       inst[11:8], 1'b0};
      IMM_U:  imm32 = {inst[31:12], 12'b0};
      IMM_J:  imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20],
                       inst[30:21], 1'b0};
      IMM_Z:  imm32 = {27'b0, inst[19:15]};
`ifdef IMM_EXTENDER_RVC_EN
      IMM_CI: imm32 = {{26{inst[12]}}, inst[12], inst[6:2]};
      IMM_CB: imm32 = {{23{inst[12]}}, inst[12], inst[6:5], inst[2],
                       inst[11:10], inst[4:3], 1'b0};
      IMM_CJ: imm32 = {{20{inst[12]}}, inst[12], inst[8], inst[10:9],
                       inst[6], inst[7], inst[2], inst[11], inst[5:3], 1'b0};
`endif
      default: begin
        imm32 = '0;
        err   = 1'b1;
      end
    endcase
  end

  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_extender_pipe.sv
// Pipelined immediate generator with an output register and a skid register.
//   clk, reset (async, active-high), flush (sync discard of held entries)
//   in_valid/in_ready/in_inst/in_immsrc/in_tag : upstream handshake
//   out_valid/out_ready/out_immext/out_tag/out_err : downstream handshake
//   dbg_state : current occupancy state
// Handshake: a transfer happens on a rising edge where valid && ready; a
// held output (valid && !ready) keeps its data stable; valid never depends
// on the same side's ready, and in_ready is a flop, not a function of
// out_ready.
// Macro IMM_EXTENDER_RVC_EN enables compressed formats in imm_extend_core.
module imm_extender_pipe
  import riscv_defines::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int TAG_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  inst_t             in_inst,
  input  immsrc_t           in_immsrc,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_immext,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_err,
  output state_e            dbg_state
);

  logic [XLEN-1:0]  core_imm;
  logic             core_err;

  imm_extend_core #(.XLEN(XLEN)) u_core (
    .inst   (in_inst),
    .immsrc (in_immsrc),
    .imm    (core_imm),
    .err    (core_err)
  );

  state_e           state_q, state_d;
  logic [XLEN-1:0]  or_imm, sk_imm;
  logic [TAG_W-1:0] or_tag, sk_tag;
  logic             or_err, sk_err;
  logic             in_xfer, out_xfer;
  logic             load_or, load_sk, or_from_sk;

  assign in_ready  = ~state_q[1];
  assign out_valid = state_q[0];
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  always_comb begin
    state_d    = state_q;
    load_or    = 1'b0;
    load_sk    = 1'b0;
    or_from_sk = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          state_d = ST_ONE;
          load_or = 1'b1;
        end
      end
      ST_ONE: begin
        if (in_xfer && out_xfer) begin
          load_or = 1'b1;
        end else if (in_xfer) begin
          state_d = ST_FULL;
          load_sk = 1'b1;
        end else if (out_xfer) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so only the skid entry can move.
        if (out_xfer) begin
          state_d    = ST_ONE;
          or_from_sk = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) begin
      state_d    = ST_EMPTY;
      load_or    = 1'b0;
      load_sk    = 1'b0;
      or_from_sk = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      or_imm  <= '0;
      or_tag  <= '0;
      or_err  <= 1'b0;
      sk_imm  <= '0;
      sk_tag  <= '0;
      sk_err  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_or) begin
        or_imm <= core_imm;
        or_tag <= in_tag;
        or_err <= core_err;
      end else if (or_from_sk) begin
        or_imm <= sk_imm;
        or_tag <= sk_tag;
        or_err <= sk_err;
      end
      if (load_sk) begin
        sk_imm <= core_imm;
        sk_tag <= in_tag;
        sk_err <= core_err;
      end
    end
  end

  assign out_immext = or_imm;
  assign out_tag    = or_tag;
  assign out_err    = or_err;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_imm_extender_pipe.sv
// Self-checking bench for imm_extender_pipe: directed cases with literal
// expectations plus randomized traffic checked against a queue-based model.
module tb_imm_extender_pipe;
  import riscv_defines::*;

  localparam int XLEN  = 32;
  localparam int TAG_W = 32;
  localparam int EW    = XLEN + TAG_W + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  inst_t             in_inst;
  immsrc_t           in_immsrc;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_immext;
  logic [TAG_W-1:0]  out_tag;
  logic              out_err;
  state_e            dbg_state;

  imm_extender_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_inst    (in_inst),
    .in_immsrc  (in_immsrc),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_immext (out_immext),
    .out_tag    (out_tag),
    .out_err    (out_err),
    .dbg_state  (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Gather the format's bits into a value of known width n, then
  // sign-extend arithmetically from bit n-1.
  function automatic logic [XLEN:0] model(input logic [31:0] i, input immsrc_t s);
    logic [63:0] v;
    int          n;
    logic        e;
    v = 0; n = 0; e = 1'b0;
    case (s)
      IMM_I:  begin v = 64'(i[31:20]); n = 12; end
      IMM_S:  begin v = 64'({i[31:25], i[11:7]}); n = 12; end
      IMM_B:  begin v = 64'({i[31], i[7], i[30:25], i[11:8], 1'b0}); n = 13; end
      IMM_U:  begin v = 64'(i[31:12]) * 4096; n = 32; end
      IMM_J:  begin v = 64'({i[31], i[19:12], i[20], i[30:21], 1'b0}); n = 21; end
      IMM_Z:  begin v = 64'(i[19:15]); n = 0; end
`ifdef IMM_EXTENDER_RVC_EN
      IMM_CI: begin v = 64'({i[12], i[6:2]}); n = 6; end
      IMM_CB: begin v = 64'({i[12], i[6:5], i[2], i[11:10], i[4:3], 1'b0}); n = 9; end
      IMM_CJ: begin v = 64'({i[12], i[8], i[10:9], i[6], i[7], i[2], i[11], i[5:3], 1'b0}); n = 12; end
`endif
      default: begin v = 0; e = 1'b1; end
    endcase
    if (n > 0) v = 64'($signed(v << (64 - n)) >>> (64 - n));
    return {e, v[XLEN-1:0]};
  endfunction

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];

  always @(posedge clk or posedge reset) begin
    logic [XLEN:0] m;
    if (reset) begin
      exp_q.delete();
    end else if (flush) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (in_valid && in_ready) begin
        m = model(in_inst, in_immsrc);
        exp_q.push_back({m[XLEN], in_tag, m[XLEN-1:0]});
      end
    end
  end

  // Compare process: occupancy, readiness and head entry every cycle.
  always @(negedge clk) begin
    chk("out_valid vs occupancy", 128'(out_valid), 128'(exp_q.size() != 0));
    chk("in_ready vs occupancy", 128'(in_ready), 128'(exp_q.size() < 2));
    if (out_valid && exp_q.size() > 0)
      chk("head entry {err,tag,imm}", 128'({out_err, out_tag, out_immext}), 128'(exp_q[0]));
  end

  // ---------------- driver tasks ----------------
  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_one(input logic [31:0] inst, input immsrc_t src, input logic [TAG_W-1:0] tag);
    in_valid  = 1'b1;
    in_inst   = inst;
    in_immsrc = src;
    in_tag    = tag;
    after_edge();
    in_valid  = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_immsrc = IMM_I; in_tag = '0;
    repeat (3) after_edge();
    chk("reset out_valid", 128'(out_valid), 128'(0));
    chk("reset in_ready", 128'(in_ready), 128'(1));
    chk("reset out_immext", 128'(out_immext), 128'(0));
    chk("reset out_tag", 128'(out_tag), 128'(0));
    chk("reset out_err", 128'(out_err), 128'(0));
    reset = 1'b0;
    out_ready = 1'b1;
    after_edge();

    // IMM_I addi x1,x0,-1
    drive_one(32'hFFF00093, IMM_I, 32'd5);
    chk("IMM_I -1 latency", 128'(out_valid), 128'(1));
    chk("IMM_I -1 value", 128'(out_immext), 128'(XLEN'(64'hFFFF_FFFF_FFFF_FFFF)));
    chk("IMM_I -1 err", 128'(out_err), 128'(0));
    chk("IMM_I -1 tag", 128'(out_tag), 128'(5));
    after_edge();

    // IMM_B beq -4
    drive_one(32'hFE000EE3, IMM_B, 32'd6);
    chk("IMM_B -4 value", 128'(out_immext), 128'(XLEN'(64'hFFFF_FFFF_FFFF_FFFC)));
    after_edge();

    // IMM_U lui with bit 31 set
    drive_one(32'h80001037, IMM_U, 32'd7);
    chk("IMM_U value", 128'(out_immext), 128'(XLEN'(64'hFFFF_FFFF_8000_1000)));
    after_edge();

    // IMM_Z csr uimm = 31, zero-extended
    drive_one(32'hFFFFFFFF, IMM_Z, 32'd8);
    chk("IMM_Z value", 128'(out_immext), 128'(31));
    after_edge();

    // c.li x1,-1
    drive_one(32'h000050FD, immsrc_t'(4'd6), 32'd9);
`ifdef IMM_EXTENDER_RVC_EN
    chk("IMM_CI value", 128'(out_immext), 128'(XLEN'(64'hFFFF_FFFF_FFFF_FFFF)));
    chk("IMM_CI err", 128'(out_err), 128'(0));
`else
    chk("code 6 unsupported value", 128'(out_immext), 128'(0));
    chk("code 6 unsupported err", 128'(out_err), 128'(1));
`endif
    after_edge();

    // Backpressure: tags 1,2,3 with consumer stalled
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h00100093; in_immsrc = IMM_I; in_tag = 32'd1;
    after_edge();
    in_tag = 32'd2;
    after_edge();
    chk("bp in_ready after 2nd accept", 128'(in_ready), 128'(0));
    in_tag = 32'd3;
    after_edge();
    chk("bp tag3 held in_ready", 128'(in_ready), 128'(0));
    chk("bp head tag", 128'(out_tag), 128'(1));
    out_ready = 1'b1;
    after_edge();
    chk("bp second tag", 128'(out_tag), 128'(2));
    chk("bp in_ready reopens", 128'(in_ready), 128'(1));
    after_edge();
    in_valid = 1'b0;
    chk("bp third tag", 128'(out_tag), 128'(3));
    after_edge();
    chk("bp drained", 128'(out_valid), 128'(0));

    // Flush while FULL with a concurrent input
    out_ready = 1'b0;
    in_valid = 1'b1; in_tag = 32'd10;
    after_edge();
    in_tag = 32'd11;
    after_edge();
    in_tag = 32'd12; flush = 1'b1;
    after_edge();
    chk("flush out_valid", 128'(out_valid), 128'(0));
    chk("flush in_ready", 128'(in_ready), 128'(1));
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      after_edge();
      chk("post-flush stays empty", 128'(out_valid), 128'(0));
    end

    // Async reset while FULL
    out_ready = 1'b0;
    in_valid = 1'b1; in_tag = 32'd20;
    after_edge();
    in_tag = 32'd21;
    after_edge();
    in_valid = 1'b0;
    chk("pre-reset full", 128'(in_ready), 128'(0));
    #2 reset = 1'b1;
    #1;
    chk("async reset out_valid", 128'(out_valid), 128'(0));
    chk("async reset in_ready", 128'(in_ready), 128'(1));
    after_edge();
    reset = 1'b0;
    after_edge();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_inst   = $urandom;
      in_immsrc = immsrc_t'(4'($urandom_range(0, 15)));
      in_tag    = $urandom;
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 99) < 3);
      after_edge();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (4) after_edge();
    chk("final drain", 128'(out_valid), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
